dsp_dot_seq: RTL



---
 rtl/dsp_ctrl_pkg.sv | 20 ++
 rtl/dsp.sv | 73 +++++++
 rtl/dsp_delay_line.sv | 27 ++
 rtl/dsp_dot_seq.sv | 136 +++++++++++++
 4 files changed

// File: rtl/dsp_ctrl_pkg.sv
// Shared DSP48 control encodings and sequencer state type for dot-product sequencing.
package dsp_ctrl_pkg;

  // OPMODE = {Z[2:0], Y[1:0], X[1:0]}
  localparam logic [6:0] OP_LOAD = 7'b000_0101;  // P = M
  localparam logic [6:0] OP_ACC  = 7'b010_0101;  // P = P + M
  localparam logic [6:0] OP_HOLD = 7'b010_0000;  // P = P
  localparam logic [6:0] OP_ZERO = 7'b000_0000;

  localparam logic [3:0] ALUMODE_ADD = 4'b0000;
  localparam logic [4:0] INMODE_A2B2 = 5'b00000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/dsp.sv
// Cycle model of a DSP48E1 slice (AREG=2, BREG=2, ADREG=1, MREG=1, PREG=1, OPMODEREG=1).
// A/B to P latency 5 cycles; free-running, no backpressure.
module dsp (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] a,
  input  logic [17:0] b,
  input  logic [47:0] c,
  input  logic [24:0] d,
  input  logic        cin,
  input  logic [6:0]  opmode,
  input  logic [3:0]  alumode,
  input  logic [4:0]  inmode,
  output logic [47:0] p
);

  logic [29:0]        a1, a2;
  logic [17:0]        b1, b2;
  logic signed [17:0] bd;
  logic signed [24:0] ad;
  logic signed [42:0] m;
  logic [6:0]         opm;
  logic [24:0]        a_pre, d_pre, ad_next;
  logic [17:0]        b_sel;
  logic [47:0]        x, y, z, p_next;

  always_comb begin
    a_pre   = inmode[1] ? 25'd0 : (inmode[0] ? a1[24:0] : a2[24:0]);
    d_pre   = inmode[2] ? d : 25'd0;
    ad_next = inmode[3] ? (d_pre - a_pre) : (d_pre + a_pre);
    b_sel   = inmode[4] ? b1 : b2;

    // The X=01/Y=01 partial-product pair is folded into X carrying the full product.
    case (opm[1:0])
      2'b01:   x = {{5{m[42]}}, m};
      2'b11:   x = {a2, b2};
      default: x = 48'd0;
    endcase
    y = (opm[3:2] == 2'b11) ? c : 48'd0;
    case (opm[6:4])
      3'b010:  z = p;
      3'b011:  z = c;
      default: z = 48'd0;
    endcase
    if (alumode == 4'b0011) p_next = z - (x + y + {47'd0, cin});
    else                    p_next = z + x + y + {47'd0, cin};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a1  <= '0;
      a2  <= '0;
      b1  <= '0;
      b2  <= '0;
      bd  <= '0;
      ad  <= '0;
      m   <= '0;
      opm <= '0;
      p   <= '0;
    end else begin
      a1  <= a;
      a2  <= a1;
      b1  <= b;
      b2  <= b1;
      ad  <= ad_next;
      bd  <= b_sel;
      m   <= ad * bd;
      opm <= opmode;
      p   <= p_next;
    end
  end

endmodule

// File: rtl/dsp_delay_line.sv
// Shift register of DEPTH stages, each WIDTH bits, flushed to RST_VAL on reset.
// Latency DEPTH cycles; no flow control, shifts every cycle.
module dsp_delay_line #(
  parameter int               WIDTH   = 7,
  parameter int               DEPTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/dsp_dot_seq.sv
// Dot-product sequencer: streams signed (a,b) pairs into a DSP48 slice and returns the 48-bit sum.
// Result P_LAT+1 cycles after the last pair; res_valid holds until res_ready, cmd_ready low meanwhile.
module dsp_dot_seq
  import dsp_ctrl_pkg::*;
#(
  parameter int LEN_W    = 8,
  parameter int OP_DELAY = 3,
  parameter int P_LAT    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      in_a,
  input  logic [17:0]      in_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data,
  output logic             busy,
  output logic [29:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [47:0]      dsp_c,
  output logic [24:0]      dsp_d,
  output logic             dsp_cin,
  output logic [6:0]       dsp_opmode,
  output logic [3:0]       dsp_alumode,
  output logic [4:0]       dsp_inmode,
  input  logic [47:0]      dsp_p
);

  localparam int CNT_W = $clog2(P_LAT + 1);

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic             first;
  logic [CNT_W-1:0] drain_cnt;
  logic [6:0]       slot_op;
  logic             beat;

  assign beat = in_valid && in_ready;

  assign dsp_c       = 48'd0;
  assign dsp_d       = 25'd0;
  assign dsp_cin     = 1'b0;
  assign dsp_alumode = ALUMODE_ADD;
  assign dsp_inmode  = INMODE_A2B2;

  // slot_op is registered alongside dsp_a/dsp_b, then delayed so OPMODE lands with M.
  dsp_delay_line #(
    .WIDTH  (7),
    .DEPTH  (OP_DELAY),
    .RST_VAL(OP_ZERO)
  ) u_op_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (slot_op),
    .dout (dsp_opmode)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      in_ready  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      busy      <= 1'b0;
      dsp_a     <= '0;
      dsp_b     <= '0;
      slot_op   <= OP_ZERO;
      remaining <= '0;
      first     <= 1'b0;
      drain_cnt <= '0;
    end else begin
      slot_op <= OP_ZERO;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_len != '0) begin
              remaining <= cmd_len;
              first     <= 1'b1;
              in_ready  <= 1'b1;
              state     <= RUN;
            end else begin
              res_data  <= '0;
              res_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        RUN: begin
          if (beat) begin
            dsp_a     <= {{5{in_a[24]}}, in_a};
            dsp_b     <= in_b;
            slot_op   <= first ? OP_LOAD : OP_ACC;
            first     <= 1'b0;
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              in_ready  <= 1'b0;
              drain_cnt <= CNT_W'(P_LAT);
              state     <= DRAIN;
            end
          end else begin
            slot_op <= OP_HOLD;
          end
        end
        DRAIN: begin
          slot_op <= OP_HOLD;
          if (drain_cnt == '0) begin
            res_data  <= dsp_p;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            drain_cnt <= drain_cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
